// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions used by the position encoder and the decoder.
// Holds the encoder FSM state type, the board cell count and the code width.
// Cell mapping: code k (1..9) <-> board bit k-1; code 0 means "no cell".
package ttt_pkg;

    localparam int unsigned NumCells  = 9;
    localparam int unsigned CodeWidth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StReport,
        StRelease
    } enc_state_e;

endpackage

// File: rtl/ttt_onehot_enc.sv
// Combinational one-hot to position-code encoder.
// Ports:
//   onehot  in  9 : candidate cell vector, bit i = cell i
//   code    out 4 : i+1 when exactly one bit i is set, otherwise 0
//   multi   out 1 : more than one bit set
module ttt_onehot_enc
    import ttt_pkg::*;
(
    input  logic [NumCells-1:0]  onehot,
    output logic [CodeWidth-1:0] code,
    output logic                 multi
);

    logic [CodeWidth-1:0] ones;
    logic [CodeWidth-1:0] idx_code;

    always_comb begin
        ones     = '0;
        idx_code = '0;
        // Scan from the top so the lowest set bit wins; only used when one-hot.
        for (int i = NumCells - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                ones     = ones + CodeWidth'(1);
                idx_code = CodeWidth'(i + 1);
            end
        end
        multi = (ones > CodeWidth'(1));
        code  = (ones == CodeWidth'(1)) ? idx_code : '0;
    end

endmodule

// File: rtl/ttt_pos_encoder.sv
// Tic-tac-toe pad position encoder.
// Synchronizes and debounces the nine raw pad inputs, then reports one accepted
// move (or an error) per stable press, and waits for a full release before the
// next press can be reported.
// Ports:
//   CLK        in  1 : system clock, rising edge
//   RST        in  1 : synchronous active-high reset
//   ENABLE     in  1 : 1 = accept pad presses
//   PAD_IN     in  9 : raw asynchronous pad presses, bit i = cell i
//   OCCUPIED   in  9 : cells already marked, synchronous
//   POS_CODE   out 4 : last reported cell code (i+1), 0 after error/reset
//   POS_VALID  out 1 : pulse, accepted move on POS_CODE
//   ERR_MULTI  out 1 : pulse, more than one pad held stably
//   ERR_TAKEN  out 1 : pulse, stable press on an occupied cell
//   BUSY       out 1 : FSM not idle
module ttt_pos_encoder
    import ttt_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [NumCells-1:0]  PAD_IN,
    input  logic [NumCells-1:0]  OCCUPIED,
    output logic [CodeWidth-1:0] POS_CODE,
    output logic                 POS_VALID,
    output logic                 ERR_MULTI,
    output logic                 ERR_TAKEN,
    output logic                 BUSY
);

    localparam logic [7:0] DebLimit = 8'(DEB_CYCLES);

    enc_state_e           state;
    logic [NumCells-1:0]  sync_a;
    logic [NumCells-1:0]  sync_b;
    logic [NumCells-1:0]  cand;
    logic [7:0]           cnt;
    logic [CodeWidth-1:0] enc_code;
    logic                 enc_multi;

    ttt_onehot_enc u_enc (
        .onehot (cand),
        .code   (enc_code),
        .multi  (enc_multi)
    );

    assign BUSY = (state != StIdle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StIdle;
            sync_a    <= '0;
            sync_b    <= '0;
            cand      <= '0;
            cnt       <= '0;
            POS_CODE  <= '0;
            POS_VALID <= 1'b0;
            ERR_MULTI <= 1'b0;
            ERR_TAKEN <= 1'b0;
        end else begin
            sync_a    <= PAD_IN;
            sync_b    <= sync_a;
            POS_VALID <= 1'b0;
            ERR_MULTI <= 1'b0;
            ERR_TAKEN <= 1'b0;

            case (state)
                StIdle: begin
                    if (ENABLE && (sync_b != '0)) begin
                        cand  <= sync_b;
                        cnt   <= 8'd1;
                        state <= StDebounce;
                    end
                end
                StDebounce: begin
                    if (!ENABLE || (sync_b != cand)) begin
                        cand  <= '0;
                        cnt   <= '0;
                        state <= StIdle;
                    end else if (cnt >= DebLimit) begin
                        // Pulses are registered on entry so they are high during REPORT.
                        cnt   <= '0;
                        state <= StReport;
                        if (enc_multi) begin
                            ERR_MULTI <= 1'b1;
                            POS_CODE  <= '0;
                        end else if ((cand & OCCUPIED) != '0) begin
                            ERR_TAKEN <= 1'b1;
                            POS_CODE  <= '0;
                        end else begin
                            POS_VALID <= 1'b1;
                            POS_CODE  <= enc_code;
                        end
                    end else if (cnt != 8'hff) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StReport: begin
                    cnt   <= '0;
                    state <= StRelease;
                end
                StRelease: begin
                    // ENABLE is ignored here: release always completes in full.
                    if (sync_b != '0) begin
                        cnt <= '0;
                    end else if (cnt >= DebLimit - 8'd1) begin
                        cnt   <= '0;
                        cand  <= '0;
                        state <= StIdle;
                    end else if (cnt != 8'hff) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    cand  <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
